rv32i_lsu: RTL and testbench

//  RV32I load/store unit: initiator side of the data-memory port (64-bit words, byte-addressed).

---
 rtl/rv32i_lsu.sv | 234 +++++++++++++++++++++++
 tb/tb_rv32i_lsu.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: validates each execute-stage access, drives a byte-lane-masked request
// onto the 64-bit data-memory port and returns aligned, sign/zero-extended load data.
module rv32i_lsu #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [1:0]            rsp_err_code,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_be,
  output logic [63:0]           mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [63:0]           mem_rdata
);

  localparam int unsigned    CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [1:0] ErrMisalign = 2'b00;
  localparam logic [1:0] ErrRange    = 2'b01;
  localparam logic [1:0] ErrIllegal  = 2'b10;
  localparam logic [1:0] ErrTimeout  = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitR, StResp} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [2:0]            off_q, off_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_be_q, mem_be_d;
  logic [63:0]           mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [1:0]            rsp_code_q, rsp_code_d;

  // Request classification; priority is illegal, then misaligned, then out of range.
  logic       legal, misaligned, out_of_range, fault;
  logic [1:0] fault_code;

  always_comb begin
    if (req_we) legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else        legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = |(req_addr >> ADDR_WIDTH);
    fault        = !legal || misaligned || out_of_range;
    if (!legal)         fault_code = ErrIllegal;
    else if (misaligned) fault_code = ErrMisalign;
    else                 fault_code = ErrRange;
  end

  logic [7:0]  be_base;
  logic [63:0] wdata_ext;

  always_comb begin
    case (req_funct3[1:0])
      2'b00: begin
        be_base   = 8'h01;
        wdata_ext = {56'b0, req_wdata[7:0]};
      end
      2'b01: begin
        be_base   = 8'h03;
        wdata_ext = {48'b0, req_wdata[15:0]};
      end
      default: begin
        be_base   = 8'h0F;
        wdata_ext = {32'b0, req_wdata};
      end
    endcase
  end

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_word;
  logic [31:0] load_data;

  always_comb begin
    rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
    rd_half = mem_rdata[{off_q[2:1], 4'b0000} +: 16];
    rd_word = mem_rdata[{off_q[2], 5'b00000} +: 32];
    case (funct3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {24'b0, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'b0, rd_half};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    // Response fields are single-cycle pulses, zero unless explicitly set below.
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    rsp_code_d  = '0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[2:0];
          if (fault) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_code_d  = fault_code;
          end else begin
            state_d     = StIssue;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_WIDTH-1:3], 3'b000};
            mem_be_d    = be_base << req_addr[2:0];
            mem_wdata_d = req_we ? (wdata_ext << {req_addr[2:0], 3'b000}) : '0;
          end
        end
      end
      StIssue: begin
        if (mem_gnt) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
          cnt_d       = '0;
          if (we_q) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = StWaitR;
          end
        end
      end
      StWaitR: begin
        if (mem_rvalid) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
        end else if (cnt_q == CntLast) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_code_d  = ErrTimeout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_code_q  <= rsp_code_d;
    end
  end

  // Gated with aresetn so the execute stage never sees ready while the unit is held in reset.
  assign req_ready    = aresetn && (state_q == StIdle);
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_err_code = rsp_code_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Bench for rv32i_lsu: scripted transaction timeline with a behavioural model of the
// access checks, lane placement and load extraction; outputs compared every cycle.
module tb_rv32i_lsu;

  localparam int unsigned AW = 15;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [1:0]    rsp_err_code;
  logic          mem_req;
  logic          mem_gnt = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_be;
  logic [63:0]   mem_wdata;
  logic          mem_rvalid = 1'b0;
  logic [63:0]   mem_rdata = '0;

  rv32i_lsu #(
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_err_code(rsp_err_code),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          exp_ready = 1'b0;
  logic          exp_mem_req = 1'b0;
  logic          exp_mem_we = 1'b0;
  logic [AW-1:0] exp_mem_addr = '0;
  logic [7:0]    exp_mem_be = '0;
  logic [63:0]   exp_mem_wdata = '0;
  logic          exp_wd_care = 1'b0;
  logic          exp_rsp_valid = 1'b0;
  logic [31:0]   exp_rsp_rdata = '0;
  logic          exp_rsp_err = 1'b0;
  logic [1:0]    exp_rsp_code = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Returns -1 for a legal access, else the error code.
  function automatic int m_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int sz;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 2;
    sz = 1 << f3[1:0];
    if ((a % sz) != 0) return 0;
    if (a >= (32'd1 << AW)) return 1;
    return -1;
  endfunction

  function automatic logic [7:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int v;
    v = ((1 << (1 << f3[1:0])) - 1) << (a % 8);
    return v[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] wd);
    logic [63:0] mask;
    mask = (64'd1 << (8 * (1 << f3[1:0]))) - 64'd1;
    return ({32'b0, wd} & mask) << (8 * (a % 8));
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [63:0] rd);
    int          sz;
    logic [63:0] v, mask;
    sz   = 1 << f3[1:0];
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v    = (rd >> (8 * (a % 8))) & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("mem_req", 64'(mem_req), 64'(exp_mem_req));
    check("mem_we", 64'(mem_we), 64'(exp_mem_we));
    check("mem_addr", 64'(mem_addr), 64'(exp_mem_addr));
    check("mem_be", 64'(mem_be), 64'(exp_mem_be));
    if (exp_wd_care || !exp_mem_req) check("mem_wdata", mem_wdata, exp_mem_wdata);
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp_valid));
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rsp_rdata));
    check("rsp_err", 64'(rsp_err), 64'(exp_rsp_err));
    check("rsp_err_code", 64'(rsp_err_code), 64'(exp_rsp_code));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_clear(input logic ready);
    exp_ready     = ready;
    exp_mem_req   = 1'b0;
    exp_mem_we    = 1'b0;
    exp_mem_addr  = '0;
    exp_mem_be    = '0;
    exp_mem_wdata = '0;
    exp_wd_care   = 1'b0;
    exp_rsp_valid = 1'b0;
    exp_rsp_rdata = '0;
    exp_rsp_err   = 1'b0;
    exp_rsp_code  = '0;
  endtask

  // Junk on inputs that must be ignored; req_valid may be high only while the LSU is busy.
  task automatic noise(input bit busy);
    req_valid  = busy ? 1'($urandom_range(0, 1)) : 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = {$urandom, $urandom};
  endtask

  // Called one step after a clock edge with the DUT idle; returns the same way.
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                         input logic [63:0] rdata);
    int code;
    code = m_fault(we, f3, addr);
    noise(0);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    exp_clear(1'b1);
    step();
    noise(1);
    if (code >= 0) begin
      exp_clear(1'b0);
      exp_rsp_valid = 1'b1;
      exp_rsp_err   = 1'b1;
      exp_rsp_code  = 2'(code);
    end else begin
      for (int k = 0; k <= gnt_dly; k++) begin
        exp_clear(1'b0);
        exp_mem_req   = 1'b1;
        exp_mem_we    = we;
        exp_mem_addr  = AW'(addr & ~32'h7);
        exp_mem_be    = m_be(f3, addr);
        exp_mem_wdata = m_wdata(f3, addr, wdata);
        exp_wd_care   = we;
        noise(1);
        mem_gnt = (k == gnt_dly);
        step();
      end
      exp_clear(1'b0);
      if (we) begin
        exp_rsp_valid = 1'b1;
      end else begin
        for (int w = 0; ; w++) begin
          exp_clear(1'b0);
          noise(1);
          mem_rvalid = (w == rv_dly);
          if (mem_rvalid) mem_rdata = rdata;
          step();
          exp_clear(1'b0);
          exp_rsp_valid = 1'b1;
          if (w == rv_dly) begin
            exp_rsp_rdata = m_rdata(f3, addr, rdata);
            break;
          end
          if (w == int'(TO) - 1) begin
            exp_rsp_err  = 1'b1;
            exp_rsp_code = 2'b11;
            break;
          end
        end
      end
    end
    noise(1);
    step();
    exp_clear(1'b1);
    noise(0);
  endtask

  task automatic reset_mid_wait();
    noise(0);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h10;
    exp_clear(1'b1);
    step();
    noise(1);
    mem_gnt     = 1'b1;
    mem_rvalid  = 1'b0;
    exp_clear(1'b0);
    exp_mem_req  = 1'b1;
    exp_mem_addr = AW'(32'h10);
    exp_mem_be   = 8'h01;
    step();
    noise(1);
    mem_rvalid = 1'b0;
    exp_clear(1'b0);
    step();
    aresetn = 1'b0;
    exp_clear(1'b0);
    noise(1);
    mem_rvalid = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    exp_clear(1'b1);
    noise(0);
    mem_rvalid = 1'b1;
    step();
    noise(0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          rv;

    // Hand-computed pins for the model.
    check("pin_sb_be", 64'(m_be(3'b000, 32'h5)), 64'h20);
    check("pin_sb_wdata", m_wdata(3'b000, 32'h5, 32'h12AB), 64'h0000_AB00_0000_0000);
    check("pin_lh", 64'(m_rdata(3'b001, 32'h6, 64'h8001_0000_0000_0000)), 64'hFFFF8001);
    check("pin_lhu", 64'(m_rdata(3'b101, 32'h6, 64'h8001_0000_0000_0000)), 64'h00008001);
    check("pin_lw_hi", 64'(m_rdata(3'b010, 32'h4, 64'h1234_5678_9ABC_DEF0)), 64'h12345678);
    check("pin_misalign", 64'(m_fault(1'b0, 3'b010, 32'h2)), 64'(0));
    check("pin_illegal", 64'(m_fault(1'b0, 3'b011, 32'h0)), 64'(2));
    check("pin_range", 64'(m_fault(1'b0, 3'b010, 32'h8000)), 64'(1));

    exp_clear(1'b0);
    step();
    step();
    aresetn = 1'b1;
    exp_clear(1'b1);
    step();

    run_txn(1'b1, 3'b000, 32'h5, 32'h12AB, 0, 0, 64'h0);
    run_txn(1'b0, 3'b001, 32'h6, 32'h0, 0, 0, 64'h8001_0000_0000_0000);
    run_txn(1'b0, 3'b101, 32'h6, 32'h0, 0, 0, 64'h8001_0000_0000_0000);
    run_txn(1'b0, 3'b010, 32'h4, 32'h0, 0, 1, 64'h1234_5678_9ABC_DEF0);
    run_txn(1'b0, 3'b010, 32'h2, 32'h0, 0, 0, 64'h0);
    run_txn(1'b0, 3'b011, 32'h0, 32'h0, 0, 0, 64'h0);
    run_txn(1'b0, 3'b010, 32'h8000, 32'h0, 0, 0, 64'h0);
    run_txn(1'b1, 3'b010, 32'h7FF8, 32'hDEADBEEF, 3, 0, 64'h0);
    run_txn(1'b0, 3'b010, 32'h0, 32'h0, 0, -1, 64'h0);
    run_txn(1'b0, 3'b100, 32'h3, 32'h0, 1, int'(TO) - 1, 64'h0000_0000_F000_0000);
    reset_mid_wait();
    run_txn(1'b0, 3'b000, 32'h17, 32'h0, 0, 0, 64'h8000_0000_0000_0000);

    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          case ($urandom_range(0, 4))
            0:       f3 = 3'b000;
            1:       f3 = 3'b001;
            2:       f3 = 3'b010;
            3:       f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
        end
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = 32'($urandom_range(0, (1 << AW) - 1));
      if ($urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      rv = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      run_txn(we, f3, addr, $urandom, int'($urandom_range(0, 3)), rv, {$urandom, $urandom});
      for (int i = int'($urandom_range(0, 2)); i > 0; i--) begin
        noise(0);
        step();
      end
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
